// File: rtl/cp0_int_ctrl_pkg.sv
// rtl/cp0_int_ctrl_pkg.sv - shared widths, register map and enable encodings for the CP0 interrupt controller
package cp0_int_ctrl_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_COUNT   = 5'd9;
    localparam logic [ADDR_W-1:0] ADDR_COMPARE = 5'd11;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 5'd22;
    localparam logic [ADDR_W-1:0] ADDR_PEND    = 5'd23;

    localparam int TIMER_EN_BIT = 31;

    localparam logic              WRITE_ENABLE = 1'b1;
    localparam logic              READ_ENABLE  = 1'b1;
    localparam logic [REG_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_W-1:0]  COMPARE_RST  = 32'hFFFF_FFFF;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// rtl/cp0_int_ctrl_if.sv - CP0-style register access port (write + combinational read)
interface cp0_int_ctrl_if;
    import cp0_int_ctrl_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [REG_W-1:0]  wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [REG_W-1:0]  data_o;

    modport master (output we, waddr, wdata, re, raddr, input data_o);
    modport slave  (input we, waddr, wdata, re, raddr, output data_o);
endinterface

// File: rtl/cp0_int_ctrl_irq_sync.sv
// rtl/cp0_int_ctrl_irq_sync.sv - one-line synchroniser with registered level and rising-edge outputs
module cp0_int_ctrl_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic                   rise_q;

    // s_q doubles as the one-cycle-delayed copy of the synchroniser output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            s_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            s_q    <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~s_q;
        end
    end

    assign s_o    = s_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/cp0_int_ctrl.sv
// rtl/cp0_int_ctrl.sv - hard-interrupt source for CP0: qualified external lines plus Count/Compare timer
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int N_IRQ       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic [N_IRQ-1:0] irq_ext,
    cp0_int_ctrl_if.slave    bus,
    output logic [N_IRQ:0]   int_o
);

    logic [N_IRQ-1:0] s;
    logic [N_IRQ-1:0] rise;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
        cp0_int_ctrl_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (cpu_clk_50M),
            .rst_ni (cpu_rst_n),
            .async_i(irq_ext[i]),
            .s_o    (s[i]),
            .rise_o (rise[i])
        );
    end

    logic [REG_W-1:0] count_q, count_d;
    logic [REG_W-1:0] compare_q, compare_d;
    logic             timer_en_q, timer_en_d;
    logic [N_IRQ-1:0] edge_mode_q, edge_mode_d;
    logic [N_IRQ-1:0] ext_pend_q, ext_pend_d;
    logic             timer_pend_q, timer_pend_d;
    logic [N_IRQ:0]   int_q;
    logic [N_IRQ-1:0] w1c;

    logic wr_count, wr_compare, wr_ctrl, wr_pend;
    assign wr_count   = (bus.we == WRITE_ENABLE) && (bus.waddr == ADDR_COUNT);
    assign wr_compare = (bus.we == WRITE_ENABLE) && (bus.waddr == ADDR_COMPARE);
    assign wr_ctrl    = (bus.we == WRITE_ENABLE) && (bus.waddr == ADDR_CTRL);
    assign wr_pend    = (bus.we == WRITE_ENABLE) && (bus.waddr == ADDR_PEND);

    always_comb begin
        count_d      = count_q;
        compare_d    = compare_q;
        timer_en_d   = timer_en_q;
        edge_mode_d  = edge_mode_q;
        w1c          = wr_pend ? bus.wdata[N_IRQ-1:0] : '0;

        if (timer_en_q) count_d = count_q + 32'd1;
        if (wr_count)   count_d = bus.wdata;
        if (wr_compare) compare_d = bus.wdata;
        if (wr_ctrl) begin
            timer_en_d  = bus.wdata[TIMER_EN_BIT];
            edge_mode_d = bus.wdata[N_IRQ-1:0];
        end

        // edge lines: a new rise beats a same-cycle clear; level lines just follow s
        ext_pend_d = (edge_mode_q & (rise | (ext_pend_q & ~w1c))) | (~edge_mode_q & s);

        timer_pend_d = timer_pend_q | (timer_en_q && (count_d == compare_q));
        if (wr_compare) timer_pend_d = 1'b0;
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            count_q      <= ZERO_WORD;
            compare_q    <= COMPARE_RST;
            timer_en_q   <= 1'b0;
            edge_mode_q  <= '0;
            ext_pend_q   <= '0;
            timer_pend_q <= 1'b0;
            int_q        <= '0;
        end else begin
            count_q      <= count_d;
            compare_q    <= compare_d;
            timer_en_q   <= timer_en_d;
            edge_mode_q  <= edge_mode_d;
            ext_pend_q   <= ext_pend_d;
            timer_pend_q <= timer_pend_d;
            int_q        <= {timer_pend_q, ext_pend_q};
        end
    end

    assign int_o = int_q;

    logic [REG_W-1:0] ctrl_rd;
    logic [REG_W-1:0] pend_rd;

    always_comb begin
        ctrl_rd               = ZERO_WORD;
        ctrl_rd[TIMER_EN_BIT] = timer_en_q;
        ctrl_rd[N_IRQ-1:0]    = edge_mode_q;
        pend_rd               = ZERO_WORD;
        pend_rd[N_IRQ:0]      = {timer_pend_q, ext_pend_q};

        bus.data_o = ZERO_WORD;
        if (cpu_rst_n && (bus.re == READ_ENABLE)) begin
            case (bus.raddr)
                ADDR_COUNT:   bus.data_o = count_q;
                ADDR_COMPARE: bus.data_o = compare_q;
                ADDR_CTRL:    bus.data_o = ctrl_rd;
                ADDR_PEND:    bus.data_o = pend_rd;
                default:      bus.data_o = ZERO_WORD;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb/tb_cp0_int_ctrl.sv - self-checking bench for cp0_int_ctrl against a behavioural model
module tb_cp0_int_ctrl;
    import cp0_int_ctrl_pkg::*;

    localparam int N_IRQ       = 5;
    localparam int SYNC_STAGES = 2;
    localparam int DLY         = SYNC_STAGES + 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [N_IRQ-1:0] irq   = '0;
    logic [N_IRQ:0]   int_o;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl #(.N_IRQ(N_IRQ), .SYNC_STAGES(SYNC_STAGES)) dut (
        .cpu_clk_50M(clk),
        .cpu_rst_n  (rst_n),
        .irq_ext    (irq),
        .bus        (bus),
        .int_o      (int_o)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: external lines are a pure delay of the samples, pend rules applied per bit
    logic [N_IRQ-1:0] hist[$];
    logic [31:0]      m_count, m_compare;
    logic             m_en, m_tpend;
    logic [N_IRQ-1:0] m_mode, m_pend;
    logic [N_IRQ:0]   m_int;

    task automatic model_reset();
        hist.delete();
        repeat (DLY + 1) hist.push_back('0);
        m_count = 0; m_compare = 32'hFFFF_FFFF; m_en = 0; m_tpend = 0;
        m_mode = 0; m_pend = 0; m_int = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            ADDR_COUNT:   return m_count;
            ADDR_COMPARE: return m_compare;
            ADDR_CTRL:    return {m_en, 26'd0, m_mode};
            ADDR_PEND:    return {26'd0, m_tpend, m_pend};
            default:      return 32'd0;
        endcase
    endfunction

    task automatic cycle();
        logic [N_IRQ-1:0] sv, sp, rs, w1c;
        logic [31:0]      nc;
        logic             wc, wcmp, wctl, wp;
        @(posedge clk);
        if (rst_n) begin
            hist.push_front(irq);
            sv = hist[DLY];
            sp = hist[DLY + 1];
            void'(hist.pop_back());
            rs   = sv & ~sp;
            wc   = bus.we && bus.waddr == ADDR_COUNT;
            wcmp = bus.we && bus.waddr == ADDR_COMPARE;
            wctl = bus.we && bus.waddr == ADDR_CTRL;
            wp   = bus.we && bus.waddr == ADDR_PEND;
            w1c  = wp ? bus.wdata[N_IRQ-1:0] : '0;
            m_int = {m_tpend, m_pend};
            for (int i = 0; i < N_IRQ; i++)
                m_pend[i] = m_mode[i] ? (rs[i] | (m_pend[i] & ~w1c[i])) : sv[i];
            nc = wc ? bus.wdata : (m_en ? m_count + 32'd1 : m_count);
            if (wcmp) m_tpend = 1'b0;
            else if (m_en && nc == m_compare) m_tpend = 1'b1;
            m_count = nc;
            if (wcmp) m_compare = bus.wdata;
            if (wctl) begin
                m_en   = bus.wdata[31];
                m_mode = bus.wdata[N_IRQ-1:0];
            end
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        cycle();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.re = 1'b1; bus.raddr = a;
        #1;
        d = bus.data_o;
        bus.re = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        irq = '0; bus.we = 0; bus.re = 0; bus.waddr = 0; bus.wdata = 0; bus.raddr = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (int_o !== 6'h00) begin n_bad++; $display("FAIL reset_int: got %h want 00", int_o); end
        rd(ADDR_COMPARE, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_read_gated: got %h want 0", d); end
        rst_n = 1'b1;
        model_reset();
        rd(ADDR_COUNT, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %h want 0", d); end
        rd(ADDR_COMPARE, d);
        n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_compare: got %h want ffffffff", d); end
        rd(ADDR_PEND, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_pend: got %h want 0", d); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        wr(ADDR_CTRL, 32'h8000_001F);
        wr(ADDR_COMPARE, 32'd3);
        wr(ADDR_COUNT, 32'd0);
        irq = '1;
        repeat (3) cycle();
        irq = '0;
        repeat (6) cycle();
        n_cmp++; if (int_o !== 6'h3F) begin n_bad++; $display("FAIL midrun_all_pend: got %h want 3f", int_o); end
        n_cmp++; if (int_o !== m_int) begin n_bad++; $display("FAIL midrun_model: got %h want %h", int_o, m_int); end
        #5 rst_n = 1'b0;
        #1;
        n_cmp++; if (int_o !== 6'h00) begin n_bad++; $display("FAIL midrun_async_clear: got %h want 00", int_o); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rd(ADDR_COUNT, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL midrun_count: got %h want 0", d); end
        rd(ADDR_COMPARE, d);
        n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL midrun_compare: got %h want ffffffff", d); end
    endtask

    task automatic test_edge();
        logic [5:0] want;
        wr(ADDR_CTRL, 32'h0000_0001);
        irq[0] = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            cycle();
            if (k == 2) irq[0] = 1'b0;
            want = (k == 4) ? 6'h01 : 6'h00;
            n_cmp++; if (int_o !== want) begin n_bad++; $display("FAIL edge_latency k=%0d: got %h want %h", k, int_o, want); end
        end
        repeat (4) cycle();
        n_cmp++; if (int_o !== 6'h01) begin n_bad++; $display("FAIL edge_sticky: got %h want 01", int_o); end
        wr(ADDR_PEND, 32'h1);
        n_cmp++; if (int_o !== 6'h01) begin n_bad++; $display("FAIL edge_w1c_lag: got %h want 01", int_o); end
        cycle();
        n_cmp++; if (int_o !== 6'h00) begin n_bad++; $display("FAIL edge_w1c: got %h want 00", int_o); end
    endtask

    task automatic test_edge_set_vs_clear();
        logic [31:0] d;
        irq[0] = 1'b1;
        repeat (3) cycle();
        wr(ADDR_PEND, 32'h1);
        cycle();
        n_cmp++; if (int_o[0] !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear_int: got %b want 1", int_o[0]); end
        rd(ADDR_PEND, d);
        n_cmp++; if (d[0] !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear_pend: got %b want 1", d[0]); end
        irq = '0;
        repeat (4) cycle();
        wr(ADDR_PEND, 32'h1F);
        cycle();
        n_cmp++; if (int_o !== m_int) begin n_bad++; $display("FAIL set_clear_cleanup: got %h want %h", int_o, m_int); end
    endtask

    task automatic test_level();
        logic want;
        wr(ADDR_CTRL, 32'h0);
        irq[3] = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k == 6) begin bus.we = 1'b1; bus.waddr = ADDR_PEND; bus.wdata = 32'h08; end
            cycle();
            bus.we = 1'b0;
            if (k == 9) irq[3] = 1'b0;
            want = (k >= 4 && k <= 13);
            n_cmp++; if (int_o[3] !== want) begin n_bad++; $display("FAIL level k=%0d: got %b want %b", k, int_o[3], want); end
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        wr(ADDR_COUNT, 32'd10);
        wr(ADDR_COMPARE, 32'd15);
        wr(ADDR_CTRL, 32'h8000_0000);
        for (int k = 1; k <= 7; k++) begin
            cycle();
            rd(ADDR_COUNT, d);
            n_cmp++; if (d !== 32'(10 + k)) begin n_bad++; $display("FAIL timer_count k=%0d: got %0d want %0d", k, d, 10 + k); end
            n_cmp++; if (int_o[5] !== (k >= 6)) begin n_bad++; $display("FAIL timer_int k=%0d: got %b want %b", k, int_o[5], k >= 6); end
        end
        wr(ADDR_COMPARE, 32'd100);
        rd(ADDR_PEND, d);
        n_cmp++; if (d[5] !== 1'b0) begin n_bad++; $display("FAIL timer_compare_clear: got %b want 0", d[5]); end
        cycle();
        n_cmp++; if (int_o[5] !== 1'b0) begin n_bad++; $display("FAIL timer_int_clear: got %b want 0", int_o[5]); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        wr(ADDR_COUNT, 32'hFFFF_FFFE);
        wr(ADDR_COMPARE, 32'd0);
        rd(ADDR_PEND, d);
        n_cmp++; if (d[5] !== 1'b0) begin n_bad++; $display("FAIL wrap_not_yet: got %b want 0", d[5]); end
        cycle();
        rd(ADDR_PEND, d);
        n_cmp++; if (d[5] !== 1'b1) begin n_bad++; $display("FAIL wrap_fire: got %b want 1", d[5]); end
        rd(ADDR_COUNT, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL wrap_count: got %h want 0", d); end
        cycle();
        wr(ADDR_COUNT, 32'hFFFF_FFFE);
        cycle();
        wr(ADDR_COMPARE, 32'd0);
        rd(ADDR_PEND, d);
        n_cmp++; if (d[5] !== 1'b0) begin n_bad++; $display("FAIL collide_clear_wins: got %b want 0", d[5]); end
        rd(ADDR_COMPARE, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL collide_compare: got %h want 0", d); end
        cycle();
        n_cmp++; if (int_o[5] !== 1'b0) begin n_bad++; $display("FAIL collide_int: got %b want 0", int_o[5]); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [4:0]  a;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) irq = 5'($urandom_range(0, 31));
            bus.we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: begin bus.waddr = ADDR_COUNT;   bus.wdata = m_compare - 32'($urandom_range(1, 6)); end
                1: begin bus.waddr = ADDR_COMPARE; bus.wdata = m_count + 32'($urandom_range(0, 6)); end
                2: begin bus.waddr = ADDR_CTRL;    bus.wdata = $urandom; end
                3: begin bus.waddr = ADDR_PEND;    bus.wdata = $urandom; end
                default: begin bus.waddr = 5'($urandom_range(0, 31)); bus.wdata = $urandom; end
            endcase
            cycle();
            bus.we = 1'b0;
            n_cmp++; if (int_o !== m_int) begin n_bad++; $display("FAIL rand_int n=%0d: got %h want %h", n, int_o, m_int); end
            a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : ((n % 2 == 0) ? ADDR_PEND : ADDR_CTRL);
            if ($urandom_range(0, 4) == 0) begin
                bus.re = 1'b0; bus.raddr = a;
                #1;
                n_cmp++; if (bus.data_o !== 32'd0) begin n_bad++; $display("FAIL rand_read_disabled: got %h want 0", bus.data_o); end
            end else begin
                rd(a, d);
                n_cmp++; if (d !== m_read(a)) begin n_bad++; $display("FAIL rand_read addr=%0d: got %h want %h", a, d, m_read(a)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_edge();
        test_edge_set_vs_clear();
        test_level();
        test_timer();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
